// File: rtl/arm_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   reg_idx_t   : register index (16 registers)
//   word_t      : register data word
//   arb_state_t : arbiter mode; FORCE stalls writeback so the aux FIFO can drain
//   REG_ZERO    : hardwired-zero register; writes to it are dropped
package arm_pkg;

    typedef logic [3:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    localparam reg_idx_t REG_ZERO = 4'd0;

endpackage

// File: rtl/aux_wr_fifo.sv
// In-order buffer for aux-unit register writes awaiting a free write port.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   push, push_dest/data  : enqueue (caller guarantees !full)
//   pop                   : dequeue head (caller guarantees !empty)
//   full, empty, count    : occupancy
//   head_dest, head_data  : oldest entry
//   ent_valid, ent_dest   : per-slot occupancy and dest, for hazard matching
module aux_wr_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_dest,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [ADDR_W-1:0]             head_dest,
    output logic [DATA_W-1:0]             head_data,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] dest_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [DEPTH-1:0]             vld;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [CNT_W-1:0]             cnt;

    // Payload storage is not reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            // Pop clears before push sets: slots only coincide when full or
            // empty, where the handshakes already exclude the other operation.
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                dest_mem[wr_ptr] <= push_dest;
                data_mem[wr_ptr] <= push_data;
                vld[wr_ptr]      <= 1'b1;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_dest = dest_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign ent_valid = vld;
    assign ent_dest  = dest_mem;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback (priority)
// and a queued aux unit. A starvation counter switches to FORCE, which stalls
// writeback until the aux queue is drained.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   wb_en/dest/value, wb_ack     : writeback request, consumed when wb_ack
//   aux_valid/dest/value, aux_ready : aux result handshake into the queue
//   rf_we/dest/data              : register file write port
//   src1/src2, pend_hit1/2       : decode sources vs. queued aux dests
//   stall_req                    : registered, high while in FORCE
module rf_write_arbiter
    import arm_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              wb_ack,
    input  logic              aux_valid,
    input  logic [ADDR_W-1:0] aux_dest,
    input  logic [DATA_W-1:0] aux_value,
    output logic              aux_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              stall_req
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT) + 1;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    arb_state_t                  state, state_nxt;
    logic [SC_W-1:0]             starve_cnt;
    logic                        stall_q;

    logic                        push, pop;
    logic                        full, empty;
    logic [CNT_W-1:0]            count;
    logic [ADDR_W-1:0]           head_dest;
    logic [DATA_W-1:0]           head_data;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;

    // Aux writes to register 0 complete the handshake but are dropped here,
    // so the queue never holds a dest-0 entry.
    assign aux_ready = !full;
    assign push      = aux_valid && aux_ready && (aux_dest != ZERO_IDX);

    aux_wr_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_dest (aux_dest),
        .push_data (aux_value),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_dest (head_dest),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_dest  (ent_dest)
    );

    always_comb begin
        state_nxt = state;
        wb_ack    = 1'b0;
        pop       = 1'b0;
        rf_we     = 1'b0;
        rf_dest   = '0;
        rf_data   = '0;
        case (state)
            NORMAL: begin
                if (wb_en) begin
                    wb_ack = 1'b1;
                    if (wb_dest != ZERO_IDX) begin
                        rf_we   = 1'b1;
                        rf_dest = wb_dest;
                        rf_data = wb_value;
                    end
                end else if (!empty) begin
                    pop     = 1'b1;
                    rf_we   = 1'b1;
                    rf_dest = head_dest;
                    rf_data = head_data;
                end
                if (!empty && !pop && starve_cnt == SC_W'(STARVE_LIMIT - 1))
                    state_nxt = FORCE;
            end
            FORCE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    rf_we   = 1'b1;
                    rf_dest = head_dest;
                    rf_data = head_data;
                end
                // Leave once this pop empties the queue (a concurrent push
                // keeps it occupied, so FORCE continues).
                if (empty || (count == CNT_W'(1) && !push))
                    state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            stall_q    <= (state_nxt == FORCE);
            starve_cnt <= (!empty && !pop) ? starve_cnt + SC_W'(1) : '0;
        end
    end

    assign stall_req = stall_q;

    // Popping entries still match this cycle; pushes are visible next cycle
    // because ent_valid is a registered view of the queue.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_dest[i] == src1) pend_hit1 = 1'b1;
            if (ent_valid[i] && ent_dest[i] == src2) pend_hit2 = 1'b1;
        end
        if (src1 == ZERO_IDX) pend_hit1 = 1'b0;
        if (src2 == ZERO_IDX) pend_hit2 = 1'b0;
    end

endmodule
